// File: rtl/icdf_horner_eval.sv
// icdf_horner_eval: pipelined Horner-form polynomial evaluator for the ICDF
// Gaussian generator. Computes y = c0 + x*(c1 + x*(c2 + ... x*cD)) on an
// unsigned fixed-point fraction x with signed per-sample coefficients.
// Pipeline: one input stage, then a multiply stage and an add stage per
// Horner step. The whole chain advances on a single enable (no skid buffer).
module icdf_horner_eval #(
  parameter int X_W     = 15,
  parameter int C_W     = 18,
  parameter int DEGREE  = 2,
  parameter int FRAC_SH = 15,
  parameter int ROUND   = 0,
  parameter int SAT     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [X_W-1:0]            x,
  input  logic [(DEGREE+1)*C_W-1:0] coef,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [C_W-1:0]            y,
  output logic                      ovf
);

  localparam int CB_W = (DEGREE + 1) * C_W;
  localparam int P_W  = C_W + X_W + 1;
  localparam int S_W  = P_W + 1;

  localparam logic signed [S_W-1:0] RND  = (ROUND != 0) ? (S_W'(1) << (FRAC_SH - 1)) : S_W'(0);
  localparam logic signed [S_W-1:0] SMAX = {{(S_W-C_W+1){1'b0}}, {(C_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] SMIN = {{(S_W-C_W+1){1'b1}}, {(C_W-1){1'b0}}};

  // S0 keeps only c0..c(D-1); cD becomes the initial accumulator.
  localparam logic [CB_W-1:0] S0_KEEP = {CB_W{1'b1}} >> C_W;

  logic w_adv;

  // Per-step boundary buses: index 0 is the input stage, index k the add
  // stage of Horner step k.
  logic                  w_av   [0:DEGREE];
  logic signed [C_W-1:0] w_acc  [0:DEGREE];
  logic                  w_aovf [0:DEGREE];
  logic [X_W-1:0]        w_ax   [0:DEGREE];
  logic [CB_W-1:0]       w_ac   [0:DEGREE];

  logic                  r_v0;
  logic signed [C_W-1:0] r_acc0;
  logic [X_W-1:0]        r_x0;
  logic [CB_W-1:0]       r_c0;

  assign w_adv     = ~out_valid | out_ready;
  assign in_ready  = w_adv;

  // Input stage valid bit
  always_ff @(posedge clk) begin
    if (rst)        r_v0 <= 1'b0;
    else if (w_adv) r_v0 <= in_valid;
  end

  // Input stage data: x, initial accumulator cD, and remaining coefficients
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_acc0 <= coef[DEGREE*C_W +: C_W];
      r_x0   <= x;
      r_c0   <= coef & S0_KEEP;
    end
  end

  assign w_av[0]   = r_v0;
  assign w_acc[0]  = r_acc0;
  assign w_aovf[0] = 1'b0;
  assign w_ax[0]   = r_x0;
  assign w_ac[0]   = r_c0;

  for (genvar k = 1; k <= DEGREE; k++) begin : g_step
    // After step k only c0..c(D-k-1) are still needed downstream.
    localparam logic [CB_W-1:0] KEEP = {CB_W{1'b1}} >> ((k + 1) * C_W);

    logic                  r_mv;
    logic signed [P_W-1:0] r_p;
    logic                  r_movf;
    logic [X_W-1:0]        r_mx;
    logic [CB_W-1:0]       r_mc;

    logic signed [S_W-1:0] w_s;
    logic                  w_hi;
    logic                  w_lo;
    logic signed [C_W-1:0] w_n;

    logic                  r_av;
    logic signed [C_W-1:0] r_acc;
    logic                  r_aovf;
    logic [X_W-1:0]        r_ax;
    logic [CB_W-1:0]       r_ac;

    // Multiply stage valid bit
    always_ff @(posedge clk) begin
      if (rst)        r_mv <= 1'b0;
      else if (w_adv) r_mv <= w_av[k-1];
    end

    // Multiply stage: acc times zero-extended x at full width, sideband forwarded
    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_p    <= P_W'(w_acc[k-1]) * P_W'($signed({1'b0, w_ax[k-1]}));
        r_movf <= w_aovf[k-1];
        r_mx   <= w_ax[k-1];
        r_mc   <= w_ac[k-1];
      end
    end

    // Align the product, add c(D-k), then clamp or wrap to C_W bits
    always_comb begin
      w_s  = ((S_W'(r_p) + RND) >>> FRAC_SH)
           + S_W'($signed(r_mc[(DEGREE-k)*C_W +: C_W]));
      w_hi = (w_s > SMAX);
      w_lo = (w_s < SMIN);
      w_n  = w_s[C_W-1:0];
      if (SAT != 0 && w_hi)      w_n = SMAX[C_W-1:0];
      else if (SAT != 0 && w_lo) w_n = SMIN[C_W-1:0];
    end

    // Add stage valid, accumulator and accumulated overflow flag
    always_ff @(posedge clk) begin
      if (rst) begin
        r_av   <= 1'b0;
        r_acc  <= '0;
        r_aovf <= 1'b0;
      end else if (w_adv) begin
        r_av   <= r_mv;
        r_acc  <= w_n;
        r_aovf <= r_movf | w_hi | w_lo;
      end
    end

    // Add stage sideband: x and the still-unconsumed coefficients
    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_ax <= r_mx;
        r_ac <= r_mc & KEEP;
      end
    end

    assign w_av[k]   = r_av;
    assign w_acc[k]  = r_acc;
    assign w_aovf[k] = r_aovf;
    assign w_ax[k]   = r_ax;
    assign w_ac[k]   = r_ac;
  end

  assign out_valid = w_av[DEGREE];
  assign y         = w_acc[DEGREE];
  assign ovf       = w_aovf[DEGREE];

endmodule

// File: tb/tb_icdf_horner_eval.sv
// Testbench for icdf_horner_eval (DEGREE=2, X_W=15, C_W=18, FRAC_SH=15).
// Three instances share stimulus: truncate+saturate, round+saturate,
// truncate+wrap. A directed vector table covers the corner values; random
// streams are scored against an integer reference model.
module tb_icdf_horner_eval;

  localparam int X_W  = 15;
  localparam int C_W  = 18;
  localparam int DEG  = 2;
  localparam int FSH  = 15;
  localparam int CB_W = (DEG + 1) * C_W;
  localparam longint YMAX = 131071;
  localparam longint YMIN = -131072;

  typedef struct {
    int xv; int c0; int c1; int c2;
    int y0; bit o0; int yr; int yw; bit ow;
  } vec_t;

  typedef struct {
    longint ym; bit om; longint yr; bit orr; longint yw; bit ow;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [X_W-1:0]  x = '0;
  logic [CB_W-1:0] coef = '0;

  logic ir_m, ir_r, ir_w;
  logic ov_m, ov_r, ov_w;
  logic f_m, f_r, f_w;
  logic signed [C_W-1:0] y_m, y_r, y_w;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int out_cnt = 0;
  int mark = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  exp_t sb[$];
  bit   stall_prev = 1'b0;
  logic signed [C_W-1:0] prev_y = '0;
  logic prev_f = 1'b0;
  vec_t tbl[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icdf_horner_eval #(.X_W(X_W), .C_W(C_W), .DEGREE(DEG), .FRAC_SH(FSH), .ROUND(0), .SAT(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_m), .x(x), .coef(coef),
    .out_valid(ov_m), .out_ready(out_ready), .y(y_m), .ovf(f_m));

  icdf_horner_eval #(.X_W(X_W), .C_W(C_W), .DEGREE(DEG), .FRAC_SH(FSH), .ROUND(1), .SAT(1)) u_rnd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_r), .x(x), .coef(coef),
    .out_valid(ov_r), .out_ready(out_ready), .y(y_r), .ovf(f_r));

  icdf_horner_eval #(.X_W(X_W), .C_W(C_W), .DEGREE(DEG), .FRAC_SH(FSH), .ROUND(0), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w), .x(x), .coef(coef),
    .out_valid(ov_w), .out_ready(out_ready), .y(y_w), .ovf(f_w));

  task automatic chk(input string nm, input longint act, input longint exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Horner evaluation with plain integer arithmetic.
  function automatic void model(input logic [X_W-1:0] xv, input logic [CB_W-1:0] cv,
                                input bit rnd, input bit sat,
                                output longint yv, output bit ov);
    longint c[3];
    longint acc, s, xl, r;
    for (int i = 0; i < 3; i++) c[i] = longint'($signed(cv[i*C_W +: C_W]));
    xl  = longint'(xv);
    r   = rnd ? (longint'(1) <<< (FSH - 1)) : longint'(0);
    acc = c[DEG];
    ov  = 1'b0;
    for (int k = 1; k <= DEG; k++) begin
      s = ((acc * xl + r) >>> FSH) + c[DEG-k];
      if (s > YMAX || s < YMIN) ov = 1'b1;
      if (sat) s = (s > YMAX) ? YMAX : ((s < YMIN) ? YMIN : s);
      else     s = s - (((s - YMIN) >>> C_W) <<< C_W);
      acc = s;
    end
    yv = acc;
  endfunction

  function automatic logic [CB_W-1:0] pack(input int a0, input int a1, input int a2);
    return {C_W'(a2), C_W'(a1), C_W'(a0)};
  endfunction

  task automatic new_sample();
    x = X_W'($urandom_range(0, (1 << X_W) - 1));
    if ($urandom_range(0, 15) == 0) x = '0;
    if ($urandom_range(0, 1) == 1)
      coef = {C_W'($urandom()), C_W'($urandom()), C_W'($urandom())};
    else
      coef = pack(int'($urandom_range(0, 4000)) - 2000,
                  int'($urandom_range(0, 4000)) - 2000,
                  int'($urandom_range(0, 4000)) - 2000);
  endtask

  // Scoreboard, handshake rule and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    longint ya;
    bit oa;
    if (rst) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      chk("in_ready_rule", longint'(ir_m), longint'(!ov_m || out_ready));
      if (stall_prev) begin
        chk("hold_valid", longint'(ov_m), 1);
        chk("hold_y", longint'(y_m), longint'(prev_y));
        chk("hold_ovf", longint'(f_m), longint'(prev_f));
      end
      if (ov_m && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got y=%0d with no sample pending, expected none", y_m);
        end else begin
          e = sb.pop_front();
          chk("sb_y", longint'(y_m), e.ym);
          chk("sb_ovf", longint'(f_m), longint'(e.om));
          chk("sb_y_round", longint'(y_r), e.yr);
          chk("sb_ovf_round", longint'(f_r), longint'(e.orr));
          chk("sb_y_wrap", longint'(y_w), e.yw);
          chk("sb_ovf_wrap", longint'(f_w), longint'(e.ow));
        end
        if (out_cnt == mark) first_cyc = cyc;
        last_cyc = cyc;
        out_cnt++;
      end
      if (in_valid && ir_m) begin
        model(x, coef, 1'b0, 1'b1, ya, oa); e.ym = ya; e.om = oa;
        model(x, coef, 1'b1, 1'b1, ya, oa); e.yr = ya; e.orr = oa;
        model(x, coef, 1'b0, 1'b0, ya, oa); e.yw = ya; e.ow = oa;
        sb.push_back(e);
      end
      stall_prev = ov_m && !out_ready;
      prev_y = y_m;
      prev_f = f_m;
    end
  end

  // One directed sample from the table, with latency measured in cycles.
  task automatic apply_row(input int i, input string tag);
    int lat;
    out_ready = 1'b1;
    x = X_W'(tbl[i].xv);
    coef = pack(tbl[i].c0, tbl[i].c1, tbl[i].c2);
    in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0;
    end while (!ov_m && lat < 20);
    chk({tag, "_latency"}, longint'(lat), 5);
    chk({tag, "_y"}, longint'(y_m), longint'(tbl[i].y0));
    chk({tag, "_ovf"}, longint'(f_m), longint'(tbl[i].o0));
    chk({tag, "_y_round"}, longint'(y_r), longint'(tbl[i].yr));
    chk({tag, "_y_wrap"}, longint'(y_w), longint'(tbl[i].yw));
    chk({tag, "_ovf_wrap"}, longint'(f_w), longint'(tbl[i].ow));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lowir;
    int n_in;
    int spurious;
    bit acc;

    tbl[0] = '{16384,  100,    2000,    4000,    2100, 1'b0,    2100,  2100, 1'b0};
    tbl[1] = '{16384,    0,       0,   -4000,   -1000, 1'b0,   -1000, -1000, 1'b0};
    tbl[2] = '{16384,    0,       0,       1,       0, 1'b0,       1,     0, 1'b0};
    tbl[3] = '{32767,    0,  131071,  131071,  131067, 1'b1,  131067,    -6, 1'b1};
    tbl[4] = '{    0, -777,       5,       9,    -777, 1'b0,    -777,  -777, 1'b0};
    tbl[5] = '{32767,    0, -131072, -131072, -131068, 1'b1, -131068,     3, 1'b1};

    // Reset state
    rst = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(ov_m), 0);
    chk("rst_y", longint'(y_m), 0);
    chk("rst_ovf", longint'(f_m), 0);
    rst = 1'b0;
    chk("rst_in_ready", longint'(ir_m), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 6; i++) apply_row(i, $sformatf("row%0d", i));

    // Back-to-back streaming
    mark = out_cnt;
    lowir = 0;
    for (int i = 0; i < 100; i++) begin
      new_sample();
      in_valid = 1'b1;
      if (!ir_m) lowir++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int t = 0; t < 40 && out_cnt < mark + 100; t++) begin
      @(posedge clk); #1;
    end
    chk("stream_count", longint'(out_cnt - mark), 100);
    chk("stream_span", longint'(last_cyc - first_cyc), 99);
    chk("stream_in_ready_low", longint'(lowir), 0);

    // Random backpressure; the source holds an offer until it is taken
    mark = out_cnt;
    n_in = 0;
    new_sample();
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = in_valid && ir_m;
      @(posedge clk); #1;
      if (acc) begin
        n_in++;
        new_sample();
      end
      out_ready = ($urandom_range(0, 1) == 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 60 && out_cnt < mark + n_in; t++) begin
      @(posedge clk); #1;
    end
    chk("bp_count", longint'(out_cnt - mark), longint'(n_in));
    chk("bp_queue_empty", longint'(sb.size()), 0);

    // Reset with three samples in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_sample();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", longint'(ov_m), 0);
    chk("midrst_y", longint'(y_m), 0);
    chk("midrst_ovf", longint'(f_m), 0);
    spurious = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov_m) spurious++;
    end
    chk("midrst_quiet", longint'(spurious), 0);
    apply_row(0, "post_rst");

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", longint'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icdf_horner_eval.md
# icdf_horner_eval

Parametrised, fully pipelined Horner-form polynomial evaluator for the ICDF Gaussian generator. It computes y = c0 + x·(c1 + x·(c2 + … x·cD)) on an unsigned fixed-point fraction x, using a signed coefficient set supplied per sample by the segment LUT. It generalises the single multiply-add stage to degree 1..4, with:
- per-step fraction alignment,
- selectable rounding and saturation,
- an overflow flag,
- a valid/ready handshake with backpressure.

It sits between the segment/coefficient lookup and the output scaling stage.

## Interface
Parameters:
- X_W, 15: width of x, unsigned fraction, value = x / 2^FRAC_SH.
- C_W, 18: coefficient, accumulator and output width, signed two's complement.
- DEGREE, 2: polynomial degree D, legal range 1..4.
- FRAC_SH, 15: arithmetic right shift applied after each multiply, legal range 1..X_W.
- ROUND, 0: 0 = truncate (floor); 1 = round half up (add 2^(FRAC_SH-1) before the shift).
- SAT, 1: 1 = saturate each add to the C_W range; 0 = two's-complement wrap.

Ports:
- clk, in, 1: clock, all logic on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- in_valid, in, 1: x and coef are valid.
- in_ready, out, 1: the block accepts a sample this cycle.
- x, in, X_W: unsigned fraction.
- coef, in, (DEGREE+1)*C_W: packed signed coefficients; bits [k*C_W +: C_W] = ck, so c0 is in the LSBs.
- out_valid, out, 1: y and ovf are valid.
- out_ready, in, 1: downstream accepts y.
- y, out, C_W: signed result.
- ovf, out, 1: an overflow occurred in at least one add step for this sample.

## Operation
- **Input stage (S0):** on accept (in_valid & in_ready), register x, all coefficients, and valid.
- **Initialisation:** acc0 = cD.
- **Step k, for k = 1..D:** two register stages.
  - Multiply stage: p = acc × zero-extended x, full width C_W+X_W+1 signed.
  - Add stage: s = ((p + R) >>> FRAC_SH) + c(D−k), computed at full width, where R = 2^(FRAC_SH−1) if ROUND=1, else 0.
- **Narrowing to C_W:**
  - SAT=1: clamp to [−2^(C_W−1), 2^(C_W−1)−1].
  - SAT=0: keep the low C_W bits.
  - In either mode, set the step's overflow bit if s lies outside that range.
- **Flag propagation:** overflow bits are OR'd down the pipeline with their sample. ovf is the OR over all D steps.
- **Sideband carry:** x and the not-yet-consumed coefficients travel with each sample. Samples never interact.
- **Flow control:** a single advance enable adv = ~out_valid | out_ready.
  - All pipeline registers, including the valid bits, load only when adv=1.
  - in_ready = adv.
  - When adv=0, every stage holds, and y/ovf stay stable while out_valid=1.
- **No state machine:** the pipeline is a valid-bit shift chain gated by adv.

## Timing
- Latency is 1 + 2·DEGREE cycles from accept to out_valid when out_ready stays high (5 cycles at DEGREE=2).
- Throughput is one sample per cycle while out_ready=1. Bubbles (in_valid=0) propagate as valid=0 slots.
- Stall behaviour:
  - The output holds as long as out_valid=1 and out_ready=0. in_ready drops in the same cycle, combinationally from out_ready.
  - The block has no skid buffer. A sample offered while in_ready=0 is not taken and must be held by the source.
- Reset values:
  - All valid bits = 0, so out_valid=0.
  - y=0, ovf=0.
  - in_ready=1 in the first cycle after reset. Data registers other than y may stay unreset.
- Reset mid-stream discards every in-flight sample. The first output after reset belongs to the first sample accepted after reset.
- Simultaneous accept and output handshakes in the same cycle are legal and lose nothing.
- Edge case, x=0: y=c0 exactly. Rounding adds 0 because (0+R)>>>FRAC_SH = 0.

## Test plan
All scenarios use DEGREE=2, X_W=15, C_W=18, FRAC_SH=15.

1. **Nominal:** x=16384, c0=100, c1=2000, c2=4000, out_ready=1 → y=2100, ovf=0, out_valid exactly 5 cycles after accept. Repeat with c2=−4000 and c0=c1=0 → y=−1000.
2. **Rounding:** x=16384, c2=1, c1=c0=0 → y=0 with ROUND=0; y=1 with ROUND=1.
3. **Saturation vs wrap:** x=32767, c2=131071, c1=131071, c0=0.
   - SAT=1 → y=131067, ovf=1.
   - SAT=0 → y=−6, ovf=1.
4. **Streaming:** 100 back-to-back random samples with out_ready=1 → outputs match a reference model in order, one per cycle after the first 5, in_ready constantly 1.
5. **Backpressure:** random out_ready (50% duty) with continuous offers → no sample lost or duplicated; y and ovf stable while out_valid=1 & out_ready=0; in_ready equals ~out_valid | out_ready every cycle.
6. **Reset mid-stream:** assert rst for 1 cycle with 3 samples in flight → out_valid=0, y=0, ovf=0 the next cycle; the next output corresponds to the first post-reset sample, 5 cycles after its accept.
